sim_run_ctrl: RTL and testbench
===============================

// Module: sim_run_ctrl
// PURPOSE
//  Parametrised run controller for the riscv_top simulation harness: generates per-domain DUT resets,
//  counts run cycles, detects DUT halt requests and (optionally) a watchdog timeout.
//  Sits between the bench clock/reset source and riscv_top (SIM=1); replaces hand-coded reset/finish loops.
//  Fully synchronous to clk; all outputs registered.
// PARAMETERS
//  RST_CYCLES   25        clk edges all dut_rst held high after rst release (0 treated as 1)
//  NUM_DOMAINS  1         number of independent dut_rst outputs
//  STAGGER      0         extra cycles between successive domain releases (domain i at RST_CYCLES+i*STAGGER)
//  CNT_W        32        width of cycle counter
//  TIMEOUT      2500000   run cycles before watchdog fires (used only with SIM_TIMEOUT_EN)
// PORTS
//  clk        in   1            clock
//  rst        in   1            asynchronous active-high reset
//  halt_req   in   1            DUT halt request (SIM stop write), sampled only in RUN
//  halt_code  in   8            exit value accompanying halt_req
//  rerun      in   1            single-cycle pulse; restarts sequence from DONE/TOUT
//  dut_rst    out  NUM_DOMAINS  per-domain DUT reset, active high
//  run        out  1            high while in RUN
//  cycle_cnt  out  CNT_W        cycles spent in RUN, saturating
//  done       out  1            sticky: halt observed
//  timeout    out  1            sticky: watchdog fired
//  exit_code  out  8            latched halt_code, or 8'hFF on timeout
// BEHAVIOUR
//  - rst high (async): state=HOLD, dut_rst=all 1, run=0, cycle_cnt=0, done=0, timeout=0, exit_code=0, hold counter=0.
//  - FSM: HOLD -> RELEASE -> RUN -> DONE | TOUT; DONE/TOUT -rerun-> HOLD.
//  - HOLD: hold counter increments each edge; at count RST_CYCLES-1 go RELEASE; dut_rst[0] drops on that same edge.
//  - RELEASE: dut_rst[i] drops i*STAGGER edges after dut_rst[0]; once dut_rst[NUM_DOMAINS-1] low, RUN next edge.
//    STAGGER=0 or NUM_DOMAINS=1: RELEASE lasts one cycle, all domains drop together.
//  - RUN: run=1; cycle_cnt increments every edge, saturates at all-ones (no wrap).
//  - halt_req in RUN: next edge state=DONE, done=1, exit_code=halt_code, run=0, cycle_cnt frozen, dut_rst stays low.
//  - halt_req outside RUN ignored; later pulses in DONE do not alter exit_code.
//  - halt_req and timeout condition in the same cycle: halt wins (done=1, timeout=0).
//  - rerun in DONE/TOUT: next edge state=HOLD, dut_rst=all 1, cycle_cnt=0, done=0, timeout=0, exit_code=0.
//    rerun in any other state ignored.
//  - rst asserted mid-RUN/RELEASE: immediate return to reset values; no partial domain release retained.
// CONFIGURATION
//  SIM_TIMEOUT_EN defined: in RUN, when cycle_cnt==TIMEOUT-1 and no halt_req -> next edge state=TOUT,
//    timeout=1, exit_code=8'hFF, run=0. TIMEOUT must fit CNT_W.
//  SIM_TIMEOUT_EN undefined: no watchdog logic; TOUT unreachable; timeout tied 0; RUN ends only on halt_req.
// STRUCTURE
//  Shared header sim_ctrl_defs.vh: state encodings (HOLD/RELEASE/RUN/DONE/TOUT, 3 bits), EXIT_TIMEOUT=8'hFF.
//  One sub-module: rst_release_cnt (per-domain down-counter, loads i*STAGGER at HOLD exit, drops its dut_rst at 0),
//  instantiated NUM_DOMAINS times via generate. Top holds FSM, cycle counter, watchdog, exit latch.
// TESTING
//  1. Defaults, rst high 3 cycles then low -> dut_rst high exactly 25 edges, run=1 on edge 26, cycle_cnt counts 0,1,2...
//  2. NUM_DOMAINS=3, STAGGER=4 -> dut_rst[0..2] drop at edges 25,29,33; run rises edge 34.
//  3. halt_req with halt_code=8'h2A at cycle_cnt=100 -> done=1, exit_code=8'h2A, cycle_cnt holds 101; later halt_req 8'h11 ignored.
//  4. SIM_TIMEOUT_EN, TIMEOUT=50, no halt -> timeout=1, exit_code=8'hFF, cycle_cnt=50; halt_req at cycle 49 -> done=1, timeout=0.
//  5. CNT_W=4, no macro -> cycle_cnt saturates at 4'hF, run stays 1; rerun pulse ignored while RUN.
//  6. rst pulse during RELEASE (scenario 2 at edge 30) -> all dut_rst high immediately; rerun from DONE restarts 25-edge hold.

Source files
------------

// File: rtl/sim_run_ctrl_pkg.sv
// Shared types for the simulation run controller: FSM state encoding and exit codes.
// The watchdog is compiled in only when SIM_TIMEOUT_EN is defined.
package sim_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TOUT    = 3'd4
  } state_e;

  localparam logic [7:0] EXIT_NONE    = 8'h00;
  localparam logic [7:0] EXIT_TIMEOUT = 8'hFF;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sim_run_ctrl_rst_release_cnt.sv
// Per-domain reset release: loads its stagger offset when HOLD ends and drops dut_rst on reaching 0.
// Unaffected by SIM_TIMEOUT_EN.
module sim_run_ctrl_rst_release_cnt
  import sim_run_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_VAL = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic load,
  output logic dut_rst
);

  localparam int unsigned   CW       = cnt_width(LOAD_VAL);
  localparam logic [CW-1:0] LOAD_CNT = CW'(LOAD_VAL);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          dut_rst_q, dut_rst_d;

  always_comb begin
    cnt_d     = cnt_q;
    dut_rst_d = dut_rst_q;
    if (hold) begin
      cnt_d     = '0;
      dut_rst_d = 1'b1;
    end else if (load) begin
      // A zero offset releases on the load edge itself.
      cnt_d     = LOAD_CNT;
      dut_rst_d = (LOAD_CNT != '0);
    end else if (cnt_q != '0) begin
      cnt_d     = cnt_q - CW'(1);
      dut_rst_d = (cnt_q != CW'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      dut_rst_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      dut_rst_q <= dut_rst_d;
    end
  end

  assign dut_rst = dut_rst_q;

endmodule

// File: rtl/sim_run_ctrl.sv
// Simulation run controller: staged DUT resets, run-cycle counter, halt capture.
// Define SIM_TIMEOUT_EN to add the watchdog (TOUT state, timeout flag, exit code 8'hFF).
//
// state    | meaning
// HOLD     | all dut_rst asserted, counting RST_CYCLES edges
// RELEASE  | domains dropping dut_rst one stagger step apart
// RUN      | DUT running, cycle_cnt advancing
// DONE     | halt observed, exit_code latched, waits for rerun
// TOUT     | watchdog fired, waits for rerun
module sim_run_ctrl
  import sim_run_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES  = 25,
  parameter int unsigned NUM_DOMAINS = 1,
  parameter int unsigned STAGGER     = 0,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT     = 2500000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   halt_req,
  input  logic [7:0]             halt_code,
  input  logic                   rerun,
  output logic [NUM_DOMAINS-1:0] dut_rst,
  output logic                   run,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic                   done,
  output logic                   timeout,
  output logic [7:0]             exit_code
);

  localparam int unsigned       RST_EFF   = (RST_CYCLES == 0) ? 1 : RST_CYCLES;
  localparam int unsigned       HOLD_W    = cnt_width(RST_EFF - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_EFF - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               run_q, run_d;
  logic [7:0]         exit_code_q, exit_code_d;
  logic               load_rel;
  logic               hold_dom;
  logic [NUM_DOMAINS-1:0] dut_rst_w;

`ifndef SIM_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = ^TO_LAST;
`endif

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    exit_code_d = exit_code_q;
    load_rel    = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_RELEASE;
          hold_cnt_d = '0;
          load_rel   = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_RELEASE: begin
        if (dut_rst_w == '0) state_d = ST_RUN;
      end
      ST_RUN: begin
        cycle_cnt_d = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
        // Halt takes priority over a coincident watchdog expiry.
        if (halt_req) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          exit_code_d = halt_code;
        end
`ifdef SIM_TIMEOUT_EN
        else if (cycle_cnt_q == TO_LAST) begin
          state_d     = ST_TOUT;
          timeout_d   = 1'b1;
          exit_code_d = EXIT_TIMEOUT;
        end
`endif
      end
      ST_DONE, ST_TOUT: begin
        if (rerun) begin
          state_d     = ST_HOLD;
          hold_cnt_d  = '0;
          cycle_cnt_d = '0;
          done_d      = 1'b0;
          timeout_d   = 1'b0;
          exit_code_d = EXIT_NONE;
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  assign run_d    = (state_d == ST_RUN);
  assign hold_dom = (state_d == ST_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      cycle_cnt_q <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      run_q       <= 1'b0;
      exit_code_q <= EXIT_NONE;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      run_q       <= run_d;
      exit_code_q <= exit_code_d;
    end
  end

  for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
    sim_run_ctrl_rst_release_cnt #(
      .LOAD_VAL(gi * STAGGER)
    ) u_rel (
      .clk     (clk),
      .rst     (rst),
      .hold    (hold_dom),
      .load    (load_rel),
      .dut_rst (dut_rst_w[gi])
    );
  end

  assign dut_rst   = dut_rst_w;
  assign run       = run_q;
  assign cycle_cnt = cycle_cnt_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign exit_code = exit_code_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: a vector table for the default controller plus hand sequences
// for staggered release, async reset, saturation and (with SIM_TIMEOUT_EN) the watchdog.
module tb_sim_run_ctrl;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // DUT A: defaults
  logic        rst_a = 1'b1, halt_a = 1'b0, rerun_a = 1'b0;
  logic [7:0]  code_a = 8'h00;
  logic [0:0]  drst_a;
  logic        run_a, done_a, tout_a;
  logic [31:0] cnt_a;
  logic [7:0]  exit_a;

  sim_run_ctrl u_a (
    .clk(clk), .rst(rst_a), .halt_req(halt_a), .halt_code(code_a), .rerun(rerun_a),
    .dut_rst(drst_a), .run(run_a), .cycle_cnt(cnt_a), .done(done_a),
    .timeout(tout_a), .exit_code(exit_a)
  );

  // DUT B: three domains, stagger 4
  logic        rst_b = 1'b1, halt_b = 1'b0, rerun_b = 1'b0;
  logic [7:0]  code_b = 8'h00;
  logic [2:0]  drst_b;
  logic        run_b, done_b, tout_b;
  logic [31:0] cnt_b;
  logic [7:0]  exit_b;

  sim_run_ctrl #(.NUM_DOMAINS(3), .STAGGER(4)) u_b (
    .clk(clk), .rst(rst_b), .halt_req(halt_b), .halt_code(code_b), .rerun(rerun_b),
    .dut_rst(drst_b), .run(run_b), .cycle_cnt(cnt_b), .done(done_b),
    .timeout(tout_b), .exit_code(exit_b)
  );

  // DUT C: 4-bit counter
  logic        rst_c = 1'b1, halt_c = 1'b0, rerun_c = 1'b0;
  logic [7:0]  code_c = 8'h00;
  logic [0:0]  drst_c;
  logic        run_c, done_c, tout_c;
  logic [3:0]  cnt_c;
  logic [7:0]  exit_c;

  sim_run_ctrl #(.CNT_W(4), .TIMEOUT(16)) u_c (
    .clk(clk), .rst(rst_c), .halt_req(halt_c), .halt_code(code_c), .rerun(rerun_c),
    .dut_rst(drst_c), .run(run_c), .cycle_cnt(cnt_c), .done(done_c),
    .timeout(tout_c), .exit_code(exit_c)
  );

  // DUT D: short watchdog
  logic        rst_d = 1'b1, halt_d = 1'b0, rerun_d = 1'b0;
  logic [7:0]  code_d = 8'h00;
  logic [0:0]  drst_d;
  logic        run_d, done_d, tout_d;
  logic [31:0] cnt_d;
  logic [7:0]  exit_d;

  sim_run_ctrl #(.TIMEOUT(50)) u_d (
    .clk(clk), .rst(rst_d), .halt_req(halt_d), .halt_code(code_d), .rerun(rerun_d),
    .dut_rst(drst_d), .run(run_d), .cycle_cnt(cnt_d), .done(done_d),
    .timeout(tout_d), .exit_code(exit_d)
  );

  typedef struct {
    int         n;
    logic       halt;
    logic [7:0] code;
    logic       rerun;
    logic       rst_o;
    logic       run_o;
    logic [31:0] cnt_o;
    logic       done_o;
    logic [7:0] exit_o;
  } vec_t;

  vec_t va[14];

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] exp_b;
    logic       exp_run;

    // inputs apply to the first edge of each row; n = edges before sampling
    va[0]  = '{24, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'd0,   1'b0, 8'h00};
    va[1]  = '{1,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'd0,   1'b0, 8'h00};
    va[2]  = '{1,  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'd0,   1'b0, 8'h00};
    va[3]  = '{1,  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'd1,   1'b0, 8'h00};
    va[4]  = '{99, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'd100, 1'b0, 8'h00};
    va[5]  = '{1,  1'b1, 8'h2A, 1'b0, 1'b0, 1'b0, 32'd101, 1'b1, 8'h2A};
    va[6]  = '{3,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'd101, 1'b1, 8'h2A};
    va[7]  = '{1,  1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 32'd101, 1'b1, 8'h2A};
    va[8]  = '{1,  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'd0,   1'b0, 8'h00};
    va[9]  = '{1,  1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 32'd0,   1'b0, 8'h00};
    va[10] = '{23, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'd0,   1'b0, 8'h00};
    va[11] = '{1,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'd0,   1'b0, 8'h00};
    va[12] = '{1,  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'd0,   1'b0, 8'h00};
    va[13] = '{5,  1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 32'd1,   1'b1, 8'h07};

    // ---- DUT A: reset values, then the vector table
    edges(3);
    chk("a_rst_dut_rst", drst_a, 1'b1);
    chk("a_rst_run", run_a, 1'b0);
    chk("a_rst_cnt", cnt_a, 32'd0);
    chk("a_rst_done", done_a, 1'b0);
    chk("a_rst_exit", exit_a, 8'h00);
    chk("a_rst_timeout", tout_a, 1'b0);
    rst_a = 1'b0;
    for (int i = 0; i < 14; i++) begin
      halt_a  = va[i].halt;
      code_a  = va[i].code;
      rerun_a = va[i].rerun;
      for (int k = 0; k < va[i].n; k++) begin
        @(posedge clk);
        #1;
        halt_a  = 1'b0;
        rerun_a = 1'b0;
      end
      chk($sformatf("a_row%0d_dut_rst", i), drst_a, va[i].rst_o);
      chk($sformatf("a_row%0d_run", i), run_a, va[i].run_o);
      chk($sformatf("a_row%0d_cnt", i), cnt_a, va[i].cnt_o);
      chk($sformatf("a_row%0d_done", i), done_a, va[i].done_o);
      chk($sformatf("a_row%0d_exit", i), exit_a, va[i].exit_o);
      chk($sformatf("a_row%0d_timeout", i), tout_a, 1'b0);
    end

    // ---- DUT B: staggered release, domain i drops at edge 25+4i, run at 34
    rst_b = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      edges(1);
      for (int d = 0; d < 3; d++) exp_b[d] = (k < 25 + 4 * d);
      exp_run = (k >= 34);
      chk($sformatf("b_edge%0d_rst_run", k), {run_b, drst_b}, {exp_run, exp_b});
    end
    chk("b_run_cnt", cnt_b, 32'd1);
    rst_b = 1'b1;
    #1;
    chk("b_async_run_rst", {run_b, drst_b}, 4'b0111);
    chk("b_async_run_cnt", cnt_b, 32'd0);
    edges(1);
    rst_b = 1'b0;
    edges(30);
    chk("b_edge30_partial", {run_b, drst_b}, 4'b0100);
    #2;
    rst_b = 1'b1;
    #1;
    chk("b_async_release_rst", {run_b, drst_b}, 4'b0111);
    edges(1);
    rst_b = 1'b0;
    edges(24);
    chk("b_again_edge24", drst_b, 3'b111);
    edges(1);
    chk("b_again_edge25", drst_b, 3'b110);
    edges(9);
    chk("b_again_edge34", {run_b, drst_b}, 4'b1000);

`ifndef SIM_TIMEOUT_EN
    // ---- DUT C: saturation, rerun ignored in RUN
    rst_c = 1'b0;
    edges(26);
    chk("c_run_start", {run_c, cnt_c}, {1'b1, 4'h0});
    edges(14);
    chk("c_cnt_e", cnt_c, 4'hE);
    edges(1);
    chk("c_cnt_f", cnt_c, 4'hF);
    rerun_c = 1'b1;
    edges(1);
    rerun_c = 1'b0;
    chk("c_rerun_ignored", {run_c, done_c, drst_c, cnt_c}, {1'b1, 1'b0, 1'b0, 4'hF});
    edges(4);
    chk("c_sat_hold", {run_c, cnt_c, tout_c}, {1'b1, 4'hF, 1'b0});
    halt_c = 1'b1;
    code_c = 8'h5A;
    edges(1);
    halt_c = 1'b0;
    chk("c_halt", {run_c, done_c, cnt_c, exit_c}, {1'b0, 1'b1, 4'hF, 8'h5A});
`endif

`ifdef SIM_TIMEOUT_EN
    // ---- DUT D: watchdog at TIMEOUT=50, then halt at cycle 49 beats it
    rst_d = 1'b0;
    edges(26);
    chk("d_run_start", {run_d, cnt_d}, {1'b1, 32'd0});
    edges(49);
    chk("d_cnt49", {run_d, tout_d, cnt_d}, {1'b1, 1'b0, 32'd49});
    edges(1);
    chk("d_timeout", {run_d, done_d, tout_d, cnt_d, exit_d}, {1'b0, 1'b0, 1'b1, 32'd50, 8'hFF});
    halt_d = 1'b1;
    code_d = 8'h22;
    edges(1);
    halt_d = 1'b0;
    edges(1);
    chk("d_tout_halt_ignored", {done_d, tout_d, exit_d}, {1'b0, 1'b1, 8'hFF});
    rerun_d = 1'b1;
    edges(1);
    rerun_d = 1'b0;
    chk("d_rerun", {drst_d, tout_d, cnt_d, exit_d}, {1'b1, 1'b0, 32'd0, 8'h00});
    edges(26);
    chk("d_rerun_run", {run_d, cnt_d}, {1'b1, 32'd0});
    edges(49);
    halt_d = 1'b1;
    code_d = 8'h3C;
    edges(1);
    halt_d = 1'b0;
    chk("d_halt_wins", {done_d, tout_d, cnt_d, exit_d}, {1'b1, 1'b0, 32'd50, 8'h3C});
    edges(3);
    chk("d_halt_stays", {done_d, tout_d, run_d}, {1'b1, 1'b0, 1'b0});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
